// File: rtl/ram_pkg.sv
// ram_pkg -- shared defaults and helpers for the ram_block register-array RAM.
package ram_pkg;

    // Default word width in bits.
    localparam int RAM_WIDTH_DEFAULT = 8;

    // Default address width in bits; the array holds 2**RAM_ADDR_DEFAULT words.
    localparam int RAM_ADDR_DEFAULT = 4;

    // Number of words addressable with addr_bits address bits.
    function automatic int ram_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage : ram_pkg

// File: rtl/ram_parity.sv
// ram_parity -- even-parity generator (XOR reduction) for one data word.
// The same module serves both the write path, which produces the stored
// parity bit, and the read path, which recomputes parity of the word on Q.
module ram_parity
    import ram_pkg::*;
#(
    parameter int Width = RAM_WIDTH_DEFAULT
) (
    input  logic [Width-1:0] i_data,
    output logic             o_parity
);

    assign o_parity = ^i_data;

endmodule : ram_parity

// File: rtl/ram_block.sv
// ram_block -- single-clock register-array RAM.
//   * one synchronous write port (we/waddr/D) and one asynchronous read
//     port (raddr/Q), with independent addresses
//   * active-low asynchronous reset clears every word while rst is low
//   * optional per-word parity, enabled by defining the macro RAM_PARITY_EN;
//     without it no parity storage exists and parity_err is tied low
module ram_block
    import ram_pkg::*;
#(
    parameter int Width       = RAM_WIDTH_DEFAULT,
    parameter int AddressSize = RAM_ADDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AddressSize-1:0] waddr,
    input  logic [Width-1:0]       D,
    input  logic [AddressSize-1:0] raddr,
    output logic [Width-1:0]       Q,
    output logic                   parity_err
);

    localparam int Depth = ram_depth(AddressSize);

    // Storage array; every address value maps to exactly one word.
    logic [Width-1:0] r_mem [Depth];

    // Word selected by the read address, before reset masking.
    logic [Width-1:0] w_rdata;

    // Data storage: clear everything on reset, otherwise write D when enabled.
    // NOTE: this array is reset word by word because the block must read 0
    // after reset; that forces flops rather than a RAM macro, which is fine
    // at these sizes. State updates use <= so every word samples the same
    // pre-edge inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= D;
        end
    end

    // Asynchronous read: Q follows raddr and the array contents with no clock.
    assign w_rdata = r_mem[raddr];
    assign Q       = rst ? w_rdata : '0;

`ifdef RAM_PARITY_EN

    // One stored parity bit per word.
    logic r_par [Depth];

    logic w_wr_parity;
    logic w_rd_parity;

    ram_parity #(
        .Width (Width)
    ) u_parity_wr (
        .i_data   (D),
        .o_parity (w_wr_parity)
    );

    ram_parity #(
        .Width (Width)
    ) u_parity_rd (
        .i_data   (w_rdata),
        .o_parity (w_rd_parity)
    );

    // Parity storage: cleared with the data so reset words check clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                r_par[i] <= 1'b0;
            end
        end else if (we) begin
            r_par[waddr] <= w_wr_parity;
        end
    end

    // Flag a mismatch between recomputed and stored parity of the read word.
    assign parity_err = rst & (w_rd_parity ^ r_par[raddr]);

`else

    assign parity_err = 1'b0;

`endif

endmodule : ram_block

// File: tb/tb_ram_block.sv
// tb_ram_block -- directed self-checking bench for ram_block (default
// parameters: 8-bit words, 16 addresses). Parity checks are compiled in
// when RAM_PARITY_EN is defined.
module tb_ram_block;

    localparam int W  = 8;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  D;
    logic [AW-1:0] raddr;
    logic [W-1:0]  Q;
    logic          parity_err;

    int n_vec;
    int n_err;

    logic [W-1:0] pattern [N];

    ram_block #(
        .Width       (W),
        .AddressSize (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .D          (D),
        .raddr      (raddr),
        .Q          (Q),
        .parity_err (parity_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one write between edges and let the next rising edge take it.
    task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        D     = d;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    // Read every address asynchronously and compare with the expected image.
    task automatic sweep(input string tag, input logic [W-1:0] img [N]);
        for (int i = 0; i < N; i++) begin
            raddr = AW'(i);
            #1;
            check($sformatf("%s Q[%0d]", tag, i), 32'(Q), 32'(img[i]));
            check($sformatf("%s perr[%0d]", tag, i), 32'(parity_err), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] zeros [N];
        n_vec = 0;
        n_err = 0;
        pattern = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12,
                    8'h01, 8'h0D, 8'h76, 8'h3D, 8'hED, 8'h8C, 8'hF9, 8'hC6};
        for (int i = 0; i < N; i++) zeros[i] = '0;

        rst   = 1'b0;
        we    = 1'b0;
        waddr = '0;
        D     = '0;
        raddr = '0;

        // Reset held: Q and parity_err are 0.
        #2;
        check("Q during reset", 32'(Q), 32'd0);
        check("perr during reset", 32'(parity_err), 32'd0);

        // A write presented while reset is low across an edge is discarded.
        we = 1'b1; waddr = 4'd4; D = 8'hA5;
        @(posedge clk); #1;
        we = 1'b0;

        // Release reset, then sweep: every word is 0.
        @(negedge clk);
        rst = 1'b1;
        sweep("post-reset", zeros);

        // First write is taken on the first rising edge after release.
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        we = 1'b1; waddr = 4'd0; D = pattern[0];
        raddr = 4'd0;
        @(posedge clk); #1;
        we = 1'b0;
        check("first write after reset", 32'(Q), 32'(pattern[0]));

        // Fill the array, reading each word back in the same time step.
        for (int i = 0; i < N; i++) begin
            write_word(AW'(i), pattern[i]);
            raddr = AW'(i);
            #0;
            check($sformatf("readback[%0d]", i), 32'(Q), 32'(pattern[i]));
        end
        sweep("full image", pattern);

        // Write-enable gating: we=0 with D=0xFF leaves address 3 alone.
        @(negedge clk);
        we = 1'b0; waddr = 4'd3; D = 8'hFF; raddr = 4'd3;
        @(posedge clk); #1;
        check("we=0 gating addr3", 32'(Q), 32'h63);

        // Multiple writes to one address: last value wins.
        write_word(4'd7, 8'h34);
        write_word(4'd7, 8'h56);
        raddr = 4'd7;
        #1;
        check("last write wins addr7", 32'(Q), 32'h56);
        pattern[7] = 8'h56;

        // Read-during-write at address 5: old word before edge, new after.
        write_word(4'd5, 8'h11);
        @(negedge clk);
        raddr = 4'd5; waddr = 4'd5; D = 8'h22; we = 1'b1;
        #1;
        check("rdw before edge", 32'(Q), 32'h11);
        @(posedge clk); #1;
        check("rdw after edge", 32'(Q), 32'h22);
        we = 1'b0;
        pattern[5] = 8'h22;

        // Raddr change alone moves Q, no clock edge needed.
        @(negedge clk);
        raddr = 4'd14;
        #1;
        check("async raddr 14", 32'(Q), 32'hF9);
        raddr = 4'd1;
        #1;
        check("async raddr 1", 32'(Q), 32'h81);

`ifdef RAM_PARITY_EN
        // Parity: clean word reads no error; a flipped data bit is flagged.
        write_word(4'd9, 8'h07);
        raddr = 4'd9;
        #1;
        check("parity clean 0x07", 32'(parity_err), 32'd0);
        force dut.w_rdata = 8'h06;
        #1;
        check("parity flipped bit", 32'(parity_err), 32'd1);
        release dut.w_rdata;
        #1;
        check("parity after release", 32'(parity_err), 32'd0);
        raddr = 4'd10;
        #1;
        check("parity unmodified addr10", 32'(parity_err), 32'd0);
        pattern[9] = 8'h07;
`endif

        // Mid-operation reset: one time-unit pulse clears everything.
        @(negedge clk);
        raddr = 4'd12;
        #1;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        sweep("after mid reset", zeros);

        // A write issued while reset spans an edge is lost.
        write_word(4'd2, 8'h3C);
        @(negedge clk);
        #4;
        rst = 1'b0; we = 1'b1; waddr = 4'd2; D = 8'h5A; raddr = 4'd2;
        #2;
        rst = 1'b1;
        we  = 1'b0;
        #1;
        check("write during reset lost", 32'(Q), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ram_block
